// File: rtl/apb3_mem_responder.sv
// rtl/apb3_mem_responder.sv - APB3 completer backed by a word-addressed memory with wait states and range errors
// Define APB3_RESP_RAND_WAIT_EN to add 0-3 LFSR-driven extra wait cycles per transfer.
module apb3_mem_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  protocol_err
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IDX_SHIFT  = $clog2(DEPTH_WORDS);
  localparam int IDX_W      = (IDX_SHIFT > 0) ? IDX_SHIFT : 1;

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [4:0]            wait_cnt;
  logic [4:0]            wait_load;
  logic                  cap_write;
  logic                  cap_in_range;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_in_range;
  logic                  setup;
  logic                  in_access;

  assign word_addr      = PADDR >> BYTE_SHIFT;
  assign setup_idx      = IDX_W'(word_addr);
  assign setup_in_range = ((word_addr >> IDX_SHIFT) == '0);
  assign setup          = (state == IDLE) && PSEL && !PENABLE;
  assign in_access      = (state == ACCESS) && PSEL && PENABLE;

`ifdef APB3_RESP_RAND_WAIT_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so wait counts vary per transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign wait_load = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign wait_load   = 5'(WAIT_STATES);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!PSEL || PREADY) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = in_access && (wait_cnt == 5'd0);
    PSLVERR = PREADY && !cap_in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= 5'd0;
      PRDATA       <= '0;
      cap_write    <= 1'b0;
      cap_in_range <= 1'b0;
      cap_idx      <= '0;
      cap_wdata    <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (setup) begin
        cap_write    <= PWRITE;
        cap_in_range <= setup_in_range;
        cap_idx      <= setup_idx;
        cap_wdata    <= PWDATA;
        wait_cnt     <= wait_load;
        if (!PWRITE) begin
          PRDATA <= setup_in_range ? mem[setup_idx] : '0;
        end
      end
      if (in_access && (wait_cnt != 5'd0)) begin
        wait_cnt <= wait_cnt - 5'd1;
      end
      if ((state == ACCESS) && !PSEL) begin
        wait_cnt <= 5'd0;
      end
      // Out-of-range writes still complete on the bus but never reach memory
      if (PREADY && cap_write && cap_in_range) begin
        mem[cap_idx] <= cap_wdata;
      end
      if (((state == IDLE) && PENABLE) || ((state == ACCESS) && (!PSEL || !PENABLE))) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb3_mem_responder.md
# apb3_mem_responder

Synthesizable APB3 completer backed by a word-addressed memory, with programmable wait states and address-range error responses. It is the responder end of the APB3 bus driven by the test-library APB3 master driver. Benches use it as a known-good target to self-check that driver and to act as a memory model behind a cpuif under test.

## Interface
Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA width in bits; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32: PADDR width in bits.
- DEPTH_WORDS, 256: number of DATA_WIDTH-bit memory words; must be a power of 2.
- WAIT_STATES, 0: base number of PREADY=0 access cycles per transfer, range 0–15.
- LFSR_SEED, 16'hACE1: nonzero seed; used only when the Configuration macro is defined.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid when PREADY=1.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; meaningful only when PREADY=1.
- protocol_err  out  1  sticky flag for an observed APB protocol violation.

## Operation
- Word index: PADDR >> log2(DATA_WIDTH/8). The low byte-offset bits are ignored.
- An index ≥ DEPTH_WORDS is out of range.
- FSM states are IDLE and ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase), capture PWRITE, the word index, PWDATA and the in-range flag.
  - Load wait_cnt with the wait count, then go to ACCESS.
  - For an in-range read, load PRDATA from memory at the same edge. An out-of-range read loads 0.
- ACCESS, with PSEL=1 and PENABLE=1:
  - If wait_cnt≠0: decrement wait_cnt and keep PREADY=0.
  - If wait_cnt=0: PREADY=1. At that edge an in-range write updates memory, then the FSM returns to IDLE.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (wait_cnt==0). It is combinational from registers and the APB inputs.
- PSLVERR = PREADY & !captured_in_range. An out-of-range write is discarded and leaves memory unchanged.
- Values captured at setup are used for the whole transfer. PADDR, PWRITE and PWDATA changes during ACCESS are ignored.
- Back-to-back transfers: the cycle after completion may be a new setup phase. IDLE accepts it with no idle gap.
- Protocol violations each set protocol_err, which stays set until rst:
  - PENABLE=1 in IDLE: the cycle is ignored and PREADY stays 0.
  - PSEL=0 while in ACCESS: the transfer is aborted, there is no memory write, and the FSM returns to IDLE.
  - PENABLE=0 with PSEL=1 in ACCESS: the FSM stays in ACCESS, wait_cnt is held, and PREADY stays 0.

## Timing
- Reset values: FSM IDLE, wait_cnt 0, PRDATA 0, PREADY 0, PSLVERR 0, protocol_err 0, every memory word 0.
- rst asserted mid-transfer aborts the transfer: no write takes place and all of the above reset values apply at the next edge.
- Transfer length with wait count N is N+2 cycles: 1 setup cycle plus N+1 access cycles. With N=0, PREADY rises in the first access cycle.
- Write data becomes visible to a read whose setup phase is on or after the completing edge.
- PRDATA holds its value until the next read setup is captured.

## Configuration
- APB3_RESP_RAND_WAIT_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with LFSR_SEED on rst and advances every cycle.
  - At setup the wait count is WAIT_STATES + lfsr[1:0], giving 0–3 extra wait cycles.
- APB3_RESP_RAND_WAIT_EN undefined: the LFSR is absent and every transfer uses exactly WAIT_STATES wait cycles.

## Test plan
- Write and read-back at WAIT_STATES=0:
  - Write 0xDEADBEEF to 0x10, then read 0x10.
  - Required: read returns 0xDEADBEEF, PSLVERR=0, each transfer is exactly 2 cycles, protocol_err=0.
- Wait states at WAIT_STATES=3:
  - Read 0x0 after reset.
  - Required: PREADY is low for 3 access cycles, the transfer takes 5 cycles, data is 0x00000000.
- Out of range at DEPTH_WORDS=256:
  - Write 0x12345678 to 0x400, then read 0x400, then read 0x0.
  - Required: both 0x400 transfers complete with PSLVERR=1, the 0x400 read returns 0, and 0x0 still reads 0.
- Protocol violations:
  - Drive PENABLE=1 with no setup phase. Required: PREADY stays 0 and protocol_err=1.
  - Separately, start a write to 0x8 with WAIT_STATES=2 and drop PSEL in its first access cycle. Required: a subsequent read of 0x8 returns 0.
- Reset mid-write:
  - Pulse rst during the access phase of a write of 0xA5A5A5A5 to 0x4 with WAIT_STATES=4.
  - Required: PREADY=0 on the next cycle, 0x4 reads 0, protocol_err=0.
- Randomized (with APB3_RESP_RAND_WAIT_EN defined):
  - Run 200 random writes and reads to in-range addresses.
  - Required: every read matches the model, each access phase lasts between WAIT_STATES+1 and WAIT_STATES+4 cycles, and no PRDATA X's.
